// File: rtl/switch_debounce_toggle_pkg.sv
// Shared types and constants for the switch debounce/toggle front end.
// Optional feature macro: SW_SYNC_EN (2-flop input synchronizer).
package switch_pkg;

   typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} deb_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

   // Debounced level implied by an FSM state: high once a press has qualified
   // and until a release has fully qualified.
   function automatic logic level_of(input deb_state_t st);
      return (st == HIGH) || (st == FALL);
   endfunction

endpackage

// File: rtl/switch_debounce_toggle_if.sv
// Switch pad / LED pad bundle for the debounce/toggle front end.
// master: drives the raw switch pins and observes the outputs (pad side).
// slave:  the debounce block itself.
interface switch_debounce_toggle_if #(
   parameter int NUM_SW = 4
);
   logic [NUM_SW-1:0] i_Switch;
   logic [NUM_SW-1:0] o_LED;
   logic [NUM_SW-1:0] o_Press_Pulse;
   logic [NUM_SW-1:0] o_Release_Pulse;
   logic [NUM_SW-1:0] o_Level;

   modport master (
      output i_Switch,
      input  o_LED,
      input  o_Press_Pulse,
      input  o_Release_Pulse,
      input  o_Level
   );

   modport slave (
      input  i_Switch,
      output o_LED,
      output o_Press_Pulse,
      output o_Release_Pulse,
      output o_Level
   );
endinterface

// File: rtl/switch_debounce_toggle_debounce_filter.sv
// Single-switch debounce filter: input sampling, LOW/RISE/HIGH/FALL FSM with
// qualification counter, registered level and one-cycle press/release pulses.
// Macro SW_SYNC_EN selects a 2-flop synchronizer instead of one input register.
module debounce_filter
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic release_strobe
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   deb_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             press_nxt, release_nxt;

`ifdef SW_SYNC_EN
   logic sync_meta, sync_s;

   // Two-stage synchronizer for the asynchronous switch pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= sw_raw;
         sync_s    <= sync_meta;
      end
   end

   assign s = sync_s;
`else
   logic sample_s;

   // Single input register on the switch pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sample_s <= 1'b0;
      else     sample_s <= sw_raw;
   end

   assign s = sample_s;
`endif

   // State, counter, level and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= LOW;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         level         <= level_of(state_nxt);
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   // Next-state, counter update and pulse decode; every terminal count leaves
   // the qualifying state, so the counter cannot wrap.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         LOW: begin
            if (s) begin
               state_nxt = RISE;
               cnt_nxt   = CNT_W'(1);
            end else begin
               cnt_nxt   = '0;
            end
         end
         RISE: begin
            if (!s) begin
               state_nxt = LOW;
               cnt_nxt   = '0;
            end else if (cnt == TERMINAL) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!s) begin
               state_nxt = FALL;
               cnt_nxt   = CNT_W'(1);
            end
         end
         FALL: begin
            if (s) begin
               state_nxt   = HIGH;
               cnt_nxt     = '0;
            end else if (cnt == TERMINAL) begin
               state_nxt   = LOW;
               cnt_nxt     = '0;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt     = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Unregistered copy of the release decision so the LED register can flip
   // in the same cycle the registered release pulse appears.
   assign release_strobe = release_nxt;

endmodule

// File: rtl/switch_debounce_toggle.sv
// Go-board push-switch front end: per-switch debounce filters plus LED toggle
// registers that flip on every debounced release.
// Macro SW_SYNC_EN enables the 2-flop input synchronizer in each filter.
module switch_debounce_toggle
   import switch_pkg::*;
#(
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst,
   switch_debounce_toggle_if.slave  sw
);

   logic [NUM_SW-1:0] level;
   logic [NUM_SW-1:0] press_pulse;
   logic [NUM_SW-1:0] release_pulse;
   logic [NUM_SW-1:0] release_strobe;
   logic [NUM_SW-1:0] led;

   for (genvar k = 0; k < NUM_SW; k++) begin : g_sw
      debounce_filter #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
         .clk           (i_Clk),
         .rst           (i_Rst),
         .sw_raw        (sw.i_Switch[k]),
         .level         (level[k]),
         .press_pulse   (press_pulse[k]),
         .release_pulse (release_pulse[k]),
         .release_strobe(release_strobe[k])
      );
   end

   // LED toggle state: flips on each qualified release, never on a press.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) led <= '0;
      else       led <= led ^ release_strobe;
   end

   assign sw.o_LED           = led;
   assign sw.o_Press_Pulse   = press_pulse;
   assign sw.o_Release_Pulse = release_pulse;
   assign sw.o_Level         = level;

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Directed, table-driven bench for switch_debounce_toggle (DEBOUNCE_CYCLES=8).
// Latency follows SW_SYNC_EN the same way the RTL build does.
module tb_switch_debounce_toggle;

   localparam int NUM_SW = 4;
   localparam int DEB    = 8;
`ifdef SW_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 1;
`endif
   // Edges after an input change where the level has not yet moved.
   localparam int unsigned PRE = DEB + SYNC_LAT - 1;

   typedef struct {
      logic [3:0]  sw;
      int unsigned cycles;
      logic [3:0]  lvl;
      logic [3:0]  prs;
      logic [3:0]  rel;
      logic [3:0]  led;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_count   = 0;
   int   miscompares = 0;
   vec_t vecs[$];

   switch_debounce_toggle_if #(.NUM_SW(NUM_SW)) sw_bus ();

   switch_debounce_toggle #(
      .NUM_SW         (NUM_SW),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .sw   (sw_bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                        input logic [3:0] rel, input logic [3:0] led);
      vec_count++;
      if (sw_bus.o_Level !== lvl || sw_bus.o_Press_Pulse !== prs ||
          sw_bus.o_Release_Pulse !== rel || sw_bus.o_LED !== led) begin
         miscompares++;
         $display("FAIL %s: got lvl=%b prs=%b rel=%b led=%b, expected lvl=%b prs=%b rel=%b led=%b",
                  name, sw_bus.o_Level, sw_bus.o_Press_Pulse, sw_bus.o_Release_Pulse,
                  sw_bus.o_LED, lvl, prs, rel, led);
      end
   endtask

   task automatic add(input logic [3:0] sw, input int unsigned cyc, input logic [3:0] lvl,
                      input logic [3:0] prs, input logic [3:0] rel, input logic [3:0] led,
                      input string name);
      vec_t v;
      v.sw = sw; v.cycles = cyc; v.lvl = lvl; v.prs = prs; v.rel = rel; v.led = led;
      v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      // Idle, clean press/release on switch 0.
      add(4'b0000, 20,  4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle");
      add(4'b0001, PRE, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "press_pre");
      add(4'b0001, 1,   4'b0001, 4'b0001, 4'b0000, 4'b0000, "press_edge");
      add(4'b0001, 1,   4'b0001, 4'b0000, 4'b0000, 4'b0000, "press_after");
      add(4'b0000, PRE, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "rel_pre");
      add(4'b0000, 1,   4'b0000, 4'b0000, 4'b0001, 4'b0001, "rel_edge");
      add(4'b0000, 1,   4'b0000, 4'b0000, 4'b0000, 4'b0001, "rel_after");
      // Bounce on switch 1: toggles every 3 cycles for 30 cycles, then rests high.
      for (int i = 0; i < 10; i++)
         add((i % 2 == 0) ? 4'b0010 : 4'b0000, 3,
             4'b0000, 4'b0000, 4'b0000, 4'b0001, "bounce");
      add(4'b0010, PRE, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "bounce_pre");
      add(4'b0010, 1,   4'b0010, 4'b0010, 4'b0000, 4'b0001, "bounce_edge");
      add(4'b0010, 1,   4'b0010, 4'b0000, 4'b0000, 4'b0001, "bounce_after");
      // 7-cycle glitch on switch 2 reaches the terminal count but never qualifies.
      add(4'b0110, 7,   4'b0010, 4'b0000, 4'b0000, 4'b0001, "glitch");
      add(4'b0010, 12,  4'b0010, 4'b0000, 4'b0000, 4'b0001, "glitch_after");
      // All switches pressed; switch 1 already high so it gives no new pulse.
      add(4'b1111, PRE, 4'b0010, 4'b0000, 4'b0000, 4'b0001, "all_pre");
      add(4'b1111, 1,   4'b1111, 4'b1101, 4'b0000, 4'b0001, "all_edge");
      add(4'b1111, 1,   4'b1111, 4'b0000, 4'b0000, 4'b0001, "all_after");

      sw_bus.i_Switch = '0;
      rst = 1'b1;
      step(3);
      check("reset_state", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         sw_bus.i_Switch = vecs[i].sw;
         step(vecs[i].cycles);
         check(vecs[i].name, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].led);
      end

      // Switches 1 and 3 released; reset lands mid FALL qualification.
      sw_bus.i_Switch = 4'b0101;
      step(7);
      check("fall_partial", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
      #1 rst = 1'b1;
      #1 check("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(3);
      check("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      // Switches 0 and 2 were held through reset and must re-qualify from LOW.
      step(PRE);
      check("requal_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      check("requal_edge", 4'b0101, 4'b0101, 4'b0000, 4'b0000);
      step(1);
      check("requal_after", 4'b0101, 4'b0000, 4'b0000, 4'b0000);
      step(12);
      check("requal_settled", 4'b0101, 4'b0000, 4'b0000, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
